// File: rtl/hall_call_dispatcher_if.sv
// Purpose : bundles the hall-call dispatcher's button, car-status and objective signals.
// Latency : n/a (wires only).
// Backpressure: none; obj_valid is a fixed-length strobe that the control unit must accept.
// Ports   : call / stateFloorA..C flow from the panel/cars; obj / obj_valid / pending
//           flow from the dispatcher. master = environment side, slave = dispatcher side.
interface hall_call_dispatcher_if #(
   parameter int FLOORS = 10
);
   logic [FLOORS-1:0] call;
   logic [5:0]        stateFloorA;
   logic [5:0]        stateFloorB;
   logic [5:0]        stateFloorC;
   logic [3:0]        obj;
   logic              obj_valid;
   logic [FLOORS-1:0] pending;

   modport master (
      output call, stateFloorA, stateFloorB, stateFloorC,
      input  obj, obj_valid, pending
   );

   modport slave (
      input  call, stateFloorA, stateFloorB, stateFloorC,
      output obj, obj_valid, pending
   );
endinterface

// File: rtl/hall_call_dispatcher.sv
// Purpose : latches hall calls, issues one objective floor at a time (round-robin), retires on car stop.
// Latency : call->pending 1 cycle, call->obj_valid 2 cycles when idle, serve->retire 1 cycle.
// Backpressure: none; obj_valid held HOLD_CYCLES cycles then >=1 idle cycle before the next issue.
// Ports   : clk, rst_n (async active-low); hc_if.slave carries call, stateFloorA/B/C
//           ({floor[3:0], up_down, en}, en=0 means stopped), obj, obj_valid, pending.
module hall_call_dispatcher #(
   parameter int FLOORS      = 10,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hall_call_dispatcher_if.slave  hc_if
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [FLOORS-1:0] pending_q, pending_d;
   logic [FLOORS-1:0] dispatched_q, dispatched_d;
   logic [3:0]        ptr_q, ptr_d;
   logic [3:0]        obj_q, obj_d;
   logic [CW-1:0]     hold_q, hold_d;

   logic [FLOORS-1:0] served;
   logic [FLOORS-1:0] eligible;
   logic [FLOORS-1:0] issue_mask;
   logic [3:0]        sel;
   logic              sel_vld;
   logic [4:0]        idx;

   // A car stopped at a floor index outside 0..FLOORS-1 matches no bit and is ignored.
   function automatic logic stopped_at(input logic [5:0] s, input int f);
      return (s[0] == 1'b0) && (s[5:2] == 4'(f));
   endfunction

   always_comb begin
      served = '0;
      for (int f = 0; f < FLOORS; f++) begin
         served[f] = stopped_at(hc_if.stateFloorA, f) |
                     stopped_at(hc_if.stateFloorB, f) |
                     stopped_at(hc_if.stateFloorC, f);
      end
   end

   // A floor already handed to the control unit stays out of selection until a car stops there.
   assign eligible = pending_q & ~dispatched_q;

   // First eligible floor at or after ptr, wrapping past FLOORS-1 back to 0.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      idx     = '0;
      for (int i = 0; i < FLOORS; i++) begin
         idx = {1'b0, ptr_q} + 5'(i);
         if (idx >= 5'(FLOORS)) begin
            idx = idx - 5'(FLOORS);
         end
         if (!sel_vld && eligible[idx[3:0]]) begin
            sel_vld = 1'b1;
            sel     = idx[3:0];
         end
      end
   end

   // FSM next-state: IDLE picks and launches a floor, ISSUE counts out the strobe.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      obj_d      = obj_q;
      hold_d     = hold_q;
      issue_mask = '0;
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               obj_d           = sel;
               issue_mask[sel] = 1'b1;
               ptr_d           = (sel == 4'(FLOORS - 1)) ? 4'd0 : sel + 4'd1;
               hold_d          = CW'(HOLD_CYCLES - 1);
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            // A serve arriving mid-strobe does not cut it short.
            if (hold_q == '0) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Clear wins over set, so a call at an occupied floor never pends.
   assign pending_d    = (pending_q | hc_if.call) & ~served;
   assign dispatched_d = (dispatched_q | issue_mask) & ~served;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         dispatched_q <= '0;
         ptr_q        <= '0;
         obj_q        <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         dispatched_q <= dispatched_d;
         ptr_q        <= ptr_d;
         obj_q        <= obj_d;
         hold_q       <= hold_d;
      end
   end

   // obj_valid comes straight from the state flop, so reset drops it without waiting for a clock.
   assign hc_if.obj       = obj_q;
   assign hc_if.obj_valid = (state_q == ISSUE);
   assign hc_if.pending   = pending_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher: directed scenarios followed by random calls and car
// movement, every cycle compared against a floor-set reference model.
module tb_hall_call_dispatcher;
   localparam int F    = 10;
   localparam int HOLD = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hall_call_dispatcher_if #(.FLOORS(F)) hc();

   hall_call_dispatcher #(.FLOORS(F), .HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hc_if (hc)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: sets of floors plus a strobe-remaining count.
   logic [F-1:0] m_pend;
   logic [F-1:0] m_disp;
   int           m_ptr;
   int           m_obj;
   int           m_left;

   function automatic logic [F-1:0] stopped_set(input logic [5:0] s);
      logic [F-1:0] m;
      int fl;
      m  = '0;
      fl = int'(s[5:2]);
      if (s[0] == 1'b0 && fl < F) m[fl] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pend = '0;
      m_disp = '0;
      m_ptr  = 0;
      m_obj  = 0;
      m_left = 0;
   endtask

   task automatic m_edge();
      logic [F-1:0] srv;
      logic [F-1:0] elig;
      logic [F-1:0] issued;
      if (!rst_n) begin
         m_reset();
      end else begin
         srv    = stopped_set(hc.stateFloorA) | stopped_set(hc.stateFloorB) |
                  stopped_set(hc.stateFloorC);
         elig   = m_pend & ~m_disp;
         issued = '0;
         if (m_left == 0) begin
            for (int k = 0; k < F; k++) begin
               int fl;
               fl = (m_ptr + k) % F;
               if (elig[fl]) begin
                  m_obj      = fl;
                  issued[fl] = 1'b1;
                  m_ptr      = (fl + 1) % F;
                  m_left     = HOLD;
                  break;
               end
            end
         end else begin
            m_left--;
         end
         m_pend = (m_pend | hc.call) & ~srv;
         m_disp = (m_disp | issued) & ~srv;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      m_edge();
      @(negedge clk);
      chk("pending", 32'(hc.pending), 32'(m_pend));
      chk("obj", 32'(hc.obj), 32'(m_obj));
      chk("obj_valid", 32'(hc.obj_valid), 32'(m_left > 0));
   endtask

   task automatic cars(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      hc.stateFloorA = a;
      hc.stateFloorB = b;
      hc.stateFloorC = c;
   endtask

   initial begin
      // Reset with random buttons pressed.
      rst_n   = 1'b0;
      hc.call = F'($urandom);
      cars(6'h00, 6'h00, 6'h00);
      m_reset();
      for (int i = 0; i < 3; i++) begin
         hc.call = F'($urandom);
         tick();
         chk("rst_pending", 32'(hc.pending), 32'h0);
         chk("rst_obj", 32'(hc.obj), 32'h0);
         chk("rst_valid", 32'(hc.obj_valid), 32'h0);
      end
      rst_n   = 1'b1;
      hc.call = '0;
      tick();

      // Single call on floor 7.
      hc.call = 10'h080;
      tick();
      chk("sc_pend", 32'(hc.pending), 32'h080);
      chk("sc_v0", 32'(hc.obj_valid), 32'h0);
      hc.call = '0;
      tick();
      chk("sc_obj", 32'(hc.obj), 32'd7);
      chk("sc_v1", 32'(hc.obj_valid), 32'h1);
      tick();
      chk("sc_v2", 32'(hc.obj_valid), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sc_noreissue", 32'(hc.obj_valid), 32'h0);
      end
      chk("sc_still_pend", 32'(hc.pending), 32'h080);
      cars(6'h00, 6'h1C, 6'h00);
      tick();
      chk("sc_retire", 32'(hc.pending), 32'h0);
      cars(6'h00, 6'h00, 6'h00);

      // Fresh reset so ptr restarts at 0, then floors 3 and 8 together.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      hc.call = 10'h108;
      tick();
      hc.call = '0;
      tick();
      chk("sim_obj3", 32'(hc.obj), 32'd3);
      chk("sim_v3", 32'(hc.obj_valid), 32'h1);
      tick();
      tick();
      chk("sim_gap", 32'(hc.obj_valid), 32'h0);
      tick();
      chk("sim_obj8", 32'(hc.obj), 32'd8);
      chk("sim_v8", 32'(hc.obj_valid), 32'h1);
      tick();
      tick();
      chk("sim_pend", 32'(hc.pending), 32'h108);

      // Round-robin: ptr sits at 9, so 9 goes before 2.
      hc.call = 10'h204;
      tick();
      hc.call = '0;
      tick();
      chk("rr_first9", 32'(hc.obj), 32'd9);
      tick();
      tick();
      tick();
      chk("rr_then2", 32'(hc.obj), 32'd2);
      chk("rr_v2", 32'(hc.obj_valid), 32'h1);
      tick();
      tick();
      cars(6'h08, 6'h0C, 6'h20);
      tick();
      chk("rr_serve3", 32'(hc.pending), 32'h200);
      cars(6'h24, 6'h00, 6'h00);
      tick();
      chk("rr_serve_all", 32'(hc.pending), 32'h0);

      // Car already stopped at floor 5: calls there never pend.
      cars(6'h14, 6'h00, 6'h00);
      hc.call = 10'h020;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("as_pend", 32'(hc.pending), 32'h0);
         chk("as_valid", 32'(hc.obj_valid), 32'h0);
      end
      cars(6'h15, 6'h00, 6'h00);
      tick();
      chk("as_moving_pend", 32'(hc.pending), 32'h020);
      hc.call = '0;
      tick();
      chk("as_obj5", 32'(hc.obj), 32'd5);
      chk("as_v5", 32'(hc.obj_valid), 32'h1);
      tick();
      tick();
      cars(6'h14, 6'h00, 6'h00);
      tick();
      cars(6'h00, 6'h00, 6'h00);

      // Serve floor 4 while its strobe is still up.
      hc.call = 10'h010;
      tick();
      hc.call = '0;
      tick();
      chk("sdi_obj4", 32'(hc.obj), 32'd4);
      cars(6'h00, 6'h00, 6'h10);
      tick();
      chk("sdi_v_hold", 32'(hc.obj_valid), 32'h1);
      chk("sdi_pend", 32'(hc.pending), 32'h0);
      cars(6'h00, 6'h00, 6'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sdi_noreissue", 32'(hc.obj_valid), 32'h0);
      end

      // Async reset in the middle of a strobe.
      hc.call = 10'h040;
      tick();
      hc.call = '0;
      tick();
      chk("ar_v_before", 32'(hc.obj_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_v_drop", 32'(hc.obj_valid), 32'h0);
      chk("ar_pend", 32'(hc.pending), 32'h0);
      chk("ar_obj", 32'(hc.obj), 32'h0);
      m_reset();
      tick();
      rst_n = 1'b1;
      tick();

      // Random calls and car motion.
      for (int n = 0; n < 600; n++) begin
         logic [F-1:0] c;
         c = '0;
         for (int b = 0; b < F; b++) c[b] = ($urandom_range(0, 9) == 0);
         hc.call = c;
         cars({4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 2) != 0)},
              {4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 2) != 0)},
              {4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom_range(0, 2) != 0)});
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
